// File: rtl/duty_slew_limiter.sv
// Duty-cycle slew limiter between filter_fsm and a pwm_generator: ramps toward the requested duty in bounded
// steps at a fixed tick rate, drops to zero at once on estop, and waits out a restart hold-off before ramping again.
module duty_slew_limiter #(
   parameter int WIDTH         = 8,
   parameter int TICK_DIV      = 50_000,
   parameter int STEP          = 4,
   parameter int RESTART_TICKS = 500
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] target_duty,
   input  logic             estop,
   output logic [WIDTH-1:0] duty_out,
   output logic             at_target,
   output logic             estopped
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int HW = $clog2(RESTART_TICKS + 1);

   localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0]    HOLD_LAST = HW'(RESTART_TICKS - 1);
   localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH-1:0] STEP_N    = WIDTH'(STEP);

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      HOLD
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_duty;
   logic [TW-1:0]    r_tick_cnt;
   logic [HW-1:0]    r_hold_cnt;
   logic             r_at_target;
   logic             r_estopped;

   state_t           w_state_next;
   logic [WIDTH-1:0] w_duty_next;
   logic [TW-1:0]    w_tick_next;
   logic [HW-1:0]    w_hold_next;

   logic             w_tick;
   logic [TW-1:0]    w_tick_adv;
   logic [WIDTH:0]   w_diff;
   logic             w_down;
   logic [WIDTH:0]   w_abs_diff;
   logic [WIDTH-1:0] w_stepped;

   assign w_tick     = (r_tick_cnt == TICK_LAST);
   assign w_tick_adv = w_tick ? '0 : r_tick_cnt + TW'(1);

   // Difference is taken one bit wider so its sign bit tells the ramp direction; when the remaining
   // distance fits in one step we land on the target exactly, so the output can neither overshoot nor wrap.
   assign w_diff     = {1'b0, target_duty} - {1'b0, r_duty};
   assign w_down     = w_diff[WIDTH];
   assign w_abs_diff = w_down ? (~w_diff + (WIDTH + 1)'(1)) : w_diff;
   assign w_stepped  = (w_abs_diff > STEP_W) ? (w_down ? r_duty - STEP_N : r_duty + STEP_N)
                                             : target_duty;

   always_comb begin
      w_state_next = r_state;
      w_duty_next  = r_duty;
      w_tick_next  = r_tick_cnt;
      w_hold_next  = r_hold_cnt;
      case (r_state)
         IDLE: begin
            w_tick_next = '0;
            if (estop) begin
               w_state_next = HOLD;
               w_duty_next  = '0;
               w_hold_next  = '0;
            end else if (target_duty != r_duty) begin
               w_state_next = RAMP;
            end
         end
         RAMP: begin
            if (estop) begin
               w_state_next = HOLD;
               w_duty_next  = '0;
               w_tick_next  = '0;
               w_hold_next  = '0;
            end else if (w_tick) begin
               w_duty_next = w_stepped;
               w_tick_next = '0;
               if (w_stepped == target_duty) begin
                  w_state_next = IDLE;
               end
            end else if (target_duty == r_duty) begin
               w_state_next = IDLE;
               w_tick_next  = '0;
            end else begin
               w_tick_next = w_tick_adv;
            end
         end
         HOLD: begin
            w_duty_next = '0;
            if (estop) begin
               w_hold_next = '0;
               w_tick_next = '0;
            end else begin
               w_tick_next = w_tick_adv;
               if (w_tick) begin
                  if (r_hold_cnt == HOLD_LAST) begin
                     w_state_next = (target_duty != '0) ? RAMP : IDLE;
                     w_tick_next  = '0;
                     w_hold_next  = '0;
                  end else begin
                     w_hold_next = r_hold_cnt + HW'(1);
                  end
               end
            end
         end
         default: begin
            w_state_next = IDLE;
            w_duty_next  = '0;
            w_tick_next  = '0;
            w_hold_next  = '0;
         end
      endcase
   end

   // Status flags are decoded from the next state so they change on the same edge as the state itself.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_duty      <= '0;
         r_tick_cnt  <= '0;
         r_hold_cnt  <= '0;
         r_at_target <= 1'b1;
         r_estopped  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_duty      <= w_duty_next;
         r_tick_cnt  <= w_tick_next;
         r_hold_cnt  <= w_hold_next;
         r_at_target <= (w_state_next == IDLE);
         r_estopped  <= (w_state_next == HOLD);
      end
   end

   assign duty_out  = r_duty;
   assign at_target = r_at_target;
   assign estopped  = r_estopped;

endmodule

// File: tb/tb_duty_slew_limiter.sv
// Directed bench for duty_slew_limiter: a per-cycle vector table for reset and ramps, then hand-written
// sequences for full-scale ramp, reversal, estop hold-off and reset while busy.
module tb_duty_slew_limiter;

   localparam int WIDTH         = 8;
   localparam int TICK_DIV      = 4;
   localparam int STEP          = 16;
   localparam int RESTART_TICKS = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] target_duty;
   logic             estop;
   logic [WIDTH-1:0] duty_out;
   logic             at_target;
   logic             estopped;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic             rst;
      logic [WIDTH-1:0] tgt;
      logic             es;
      logic [WIDTH-1:0] expDuty;
      logic             expAt;
      logic             expEs;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   duty_slew_limiter #(
      .WIDTH(WIDTH),
      .TICK_DIV(TICK_DIV),
      .STEP(STEP),
      .RESTART_TICKS(RESTART_TICKS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .target_duty(target_duty),
      .estop(estop),
      .duty_out(duty_out),
      .at_target(at_target),
      .estopped(estopped)
   );

   function automatic void addRep(input int n, input logic rst, input logic [WIDTH-1:0] tgt, input logic es,
                                  input logic [WIDTH-1:0] d, input logic at, input logic e);
      vec_t v;
      v.rst = rst; v.tgt = tgt; v.es = es; v.expDuty = d; v.expAt = at; v.expEs = e;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input logic rst, input logic [WIDTH-1:0] tgt, input logic es);
      reset       = rst;
      target_duty = tgt;
      estop       = es;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] d, input logic at, input logic e);
      checks++;
      if (duty_out !== d) begin
         errors++;
         $display("[TB] FAIL %s duty_out: got %0d expected %0d", name, duty_out, d);
      end
      checks++;
      if (at_target !== at) begin
         errors++;
         $display("[TB] FAIL %s at_target: got %b expected %b", name, at_target, at);
      end
      checks++;
      if (estopped !== e) begin
         errors++;
         $display("[TB] FAIL %s estopped: got %b expected %b", name, estopped, e);
      end
   endtask

   task automatic stepCheck(input string name, input logic rst, input logic [WIDTH-1:0] tgt, input logic es,
                            input logic [WIDTH-1:0] d, input logic at, input logic e);
      applyStimulus(rst, tgt, es);
      checkOutput(name, d, at, e);
   endtask

   initial begin
      logic [WIDTH-1:0] expD;

      reset       = 1'b0;
      target_duty = 8'd100;
      estop       = 1'b0;

      // reset held with a nonzero target, then idle at zero
      addRep(3, 1'b0, 8'd100, 1'b0, 8'd0, 1'b1, 1'b0);
      addRep(1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      // ramp up 0 -> 64
      addRep(4, 1'b1, 8'd64, 1'b0, 8'd0, 1'b0, 1'b0);
      addRep(4, 1'b1, 8'd64, 1'b0, 8'd16, 1'b0, 1'b0);
      addRep(4, 1'b1, 8'd64, 1'b0, 8'd32, 1'b0, 1'b0);
      addRep(4, 1'b1, 8'd64, 1'b0, 8'd48, 1'b0, 1'b0);
      addRep(2, 1'b1, 8'd64, 1'b0, 8'd64, 1'b1, 1'b0);
      // clamped ramp down 64 -> 10
      addRep(4, 1'b1, 8'd10, 1'b0, 8'd64, 1'b0, 1'b0);
      addRep(4, 1'b1, 8'd10, 1'b0, 8'd48, 1'b0, 1'b0);
      addRep(4, 1'b1, 8'd10, 1'b0, 8'd32, 1'b0, 1'b0);
      addRep(4, 1'b1, 8'd10, 1'b0, 8'd16, 1'b0, 1'b0);
      addRep(2, 1'b1, 8'd10, 1'b0, 8'd10, 1'b1, 1'b0);

      foreach (vecs[i]) begin
         stepCheck($sformatf("vec%0d", i), vecs[i].rst, vecs[i].tgt, vecs[i].es,
                   vecs[i].expDuty, vecs[i].expAt, vecs[i].expEs);
      end

      // 10 -> 0 in a single partial step, then full scale 0 -> 255 with no wrap
      for (int c = 0; c < 4; c++) stepCheck($sformatf("down0_c%0d", c), 1'b1, 8'd0, 1'b0, 8'd10, 1'b0, 1'b0);
      stepCheck("down0_end", 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      for (int c = 0; c <= 64; c++) begin
         expD = (c == 64) ? 8'd255 : 8'((c / 4) * 16);
         stepCheck($sformatf("full_c%0d", c), 1'b1, 8'd255, 1'b0, expD, (c == 64), 1'b0);
      end
      stepCheck("full_hold", 1'b1, 8'd255, 1'b0, 8'd255, 1'b1, 1'b0);

      // reversal: head for 128, switch to 0 once 32 is reached
      stepCheck("rev_reset", 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      for (int c = 0; c <= 8; c++)
         stepCheck($sformatf("rev_up_c%0d", c), 1'b1, 8'd128, 1'b0, 8'((c / 4) * 16), 1'b0, 1'b0);
      for (int c = 9; c <= 16; c++) begin
         expD = (c < 12) ? 8'd32 : ((c < 16) ? 8'd16 : 8'd0);
         stepCheck($sformatf("rev_dn_c%0d", c), 1'b1, 8'd0, 1'b0, expD, (c == 16), 1'b0);
      end

      // estop pulse at 48, hold-off, resume ramp
      for (int c = 0; c <= 12; c++)
         stepCheck($sformatf("es_up_c%0d", c), 1'b1, 8'd128, 1'b0, 8'((c / 4) * 16), 1'b0, 1'b0);
      stepCheck("es_hit", 1'b1, 8'd128, 1'b1, 8'd0, 1'b0, 1'b1);
      for (int j = 1; j <= 7; j++)
         stepCheck($sformatf("es_hold_j%0d", j), 1'b1, 8'd128, 1'b0, 8'd0, 1'b0, 1'b1);
      for (int j = 8; j <= 20; j++)
         stepCheck($sformatf("es_resume_j%0d", j), 1'b1, 8'd128, 1'b0, 8'(((j - 8) / 4) * 16), 1'b0, 1'b0);

      // second estop re-asserted six cycles into the hold restarts the full wait
      stepCheck("es2_hit", 1'b1, 8'd128, 1'b1, 8'd0, 1'b0, 1'b1);
      for (int j = 1; j <= 13; j++)
         stepCheck($sformatf("es2_hold_j%0d", j), 1'b1, 8'd128, (j == 6), 8'd0, 1'b0, 1'b1);
      for (int j = 14; j <= 22; j++)
         stepCheck($sformatf("es2_resume_j%0d", j), 1'b1, 8'd128, 1'b0, 8'(((j - 14) / 4) * 16), 1'b0, 1'b0);

      // reset while ramping at 32, then reset while holding
      stepCheck("rst_ramp", 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      stepCheck("rst_to_hold", 1'b1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1);
      for (int j = 0; j < 3; j++)
         stepCheck($sformatf("rst_hold_j%0d", j), 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
      stepCheck("rst_hold", 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      for (int j = 0; j < 10; j++)
         stepCheck($sformatf("rst_idle_j%0d", j), 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/duty_slew_limiter.md
Name: duty_slew_limiter

Overview:
- Sits between filter_fsm and each pwm_generator, one instance per pump.
- Takes the FSM's requested duty cycle and moves its output toward it in bounded steps at a fixed tick rate, so pumps soft-start and soft-stop with no current surges.
- An emergency-stop input forces 0 duty at once. A restart hold-off must expire before ramping resumes.

Parameters:
- WIDTH, 8, duty word width; matches the pwm_generator duty_cycle input.
- TICK_DIV, 50_000, clock cycles per ramp tick (1 ms at 50 MHz); legal range >= 2.
- STEP, 4, maximum duty change per tick; legal range 1 .. 2^WIDTH-1.
- RESTART_TICKS, 500, ticks estop must stay low before ramping resumes; legal range >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- target_duty  input  WIDTH  requested duty from filter_fsm; may change on any cycle.
- estop  input  1  emergency stop, active high, already synchronous to clk.
- duty_out  output  WIDTH  limited duty to pwm_generator; registered.
- at_target  output  1  high while in IDLE (duty_out == target_duty); registered state decode.
- estopped  output  1  high while in HOLD; registered state decode.

Behaviour:
- Reset: on any clk edge with reset=0: state=IDLE, duty_out=0, tick_cnt=0, hold_cnt=0, at_target=1, estopped=0. Reset overrides every other input, including mid-ramp and mid-hold.
- Tick counter:
  - tick_cnt is held at 0 in IDLE.
  - In RAMP and HOLD it counts 0..TICK_DIV-1 and wraps to 0.
  - A tick is the cycle on which tick_cnt == TICK_DIV-1.
  - The first tick after entering RAMP or HOLD falls TICK_DIV cycles after entry.
- Step arithmetic:
  - diff = target_duty - duty_out, computed in WIDTH+1 bits, signed.
  - On a tick: duty_out moves toward target_duty by min(STEP, |diff|). It never overshoots and never wraps; 255 and 0 are reachable exactly.
- States, priority estop > target:
  - IDLE:
    - If estop=1: go to HOLD; duty_out<=0.
    - Else if target_duty != duty_out: go to RAMP; tick_cnt<=0.
    - Otherwise stay in IDLE.
  - RAMP:
    - If estop=1: go to HOLD; duty_out<=0; tick_cnt<=0; hold_cnt<=0.
    - Else on a tick: apply the step. If the stepped value equals target_duty, go to IDLE.
    - Else on a non-tick cycle with target_duty == duty_out: go to IDLE.
    - target_duty is re-sampled every tick. A direction reversal mid-ramp simply steps the other way; no dwell.
  - HOLD:
    - duty_out is held at 0.
    - If estop=1: hold_cnt<=0 and tick_cnt<=0.
    - Else on each tick: hold_cnt++. When hold_cnt reaches RESTART_TICKS: go to RAMP if target_duty != 0, else go to IDLE; tick_cnt<=0.
- Latency:
  - Stop: estop sampled high at edge k gives duty_out=0 visible after edge k.
  - Target change: target_duty changed before edge k gives the first step visible after edge k+TICK_DIV. IDLE→RAMP takes edge k; the first tick falls TICK_DIV-1 cycles later.
- Simultaneous events: an estop on a tick cycle wins; no step is applied. A target change on the same cycle that RAMP reaches target is evaluated at the next IDLE cycle.
- at_target and estopped are never high together.

Test Plan (bench params TICK_DIV=4, STEP=16, RESTART_TICKS=2):
- Reset: hold reset=0 for 3 cycles with target_duty=100 -> duty_out=0, at_target=1, estopped=0 throughout.
- Ramp up: target_duty 0→64 in IDLE -> duty_out 16, 32, 48, 64, spaced 4 cycles apart with the first 4 cycles after the change. at_target=0 during the ramp and =1 on the cycle after 64 is reached.
- Clamped ramp down: from 64 set target_duty=10 -> duty_out 48, 32, 16, 10. Never below 10, then IDLE. Separately, target 255 from 0 ends …, 240, 255 with no wrap.
- Reversal: ramping 0→128, set target_duty=0 when duty_out=32 -> next ticks 16, 0, then IDLE.
- Estop: at duty_out=48 pulse estop for 1 cycle -> duty_out=0 the next cycle and estopped=1. After 8 cycles with estop low, RAMP resumes 16, 32, 48 at 4-cycle spacing. A second estop at cycle 6 of the hold restarts the full 8-cycle wait.
- Reset mid-operation: assert reset=0 during RAMP at duty_out=32 and during HOLD -> next edge duty_out=0, state IDLE. After release, a target of 0 stays IDLE with no ramp.
